// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave                                                       |
// | Purpose  : SPI responder, MSB-first, full duplex, all four CPOL/CPHA modes.|
// |            Runs entirely in the clk domain; sclk/ss/mosi are synchronized  |
// |            and edge-detected, sclk is never used as a clock.               |
// | Ports    : clk, rst       - system clock, synchronous active-high reset    |
// |            cpol, cpha     - SPI mode, latched when ss falls                |
// |            sclk, ss, mosi - asynchronous bus inputs from the master        |
// |            data_in        - word to transmit                               |
// |            miso, miso_oe  - serial data out and its pad enable             |
// |            busy           - transaction in progress                        |
// |            rx_valid       - one-cycle strobe, data_out just updated        |
// |            data_out       - last complete received word                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  input  logic [WIDTH-1:0] data_in,
  output logic             miso,
  output logic             miso_oe,
  output logic             busy,
  output logic             rx_valid,
  output logic [WIDTH-1:0] data_out
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchronizers and registered edge flags
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;
  logic                   r_mosi_q;
  logic                   r_sclk_rise;
  logic                   r_sclk_fall;
  logic                   r_ss_rise;
  logic                   r_ss_fall;

  // Datapath
  logic             r_cpol;
  logic             r_cpha;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_rx;
  logic [WIDTH-1:0] r_tx;
  logic             r_reload;
  logic             r_miso;
  logic             r_miso_oe;
  logic             r_busy;
  logic             r_rx_valid;
  logic [WIDTH-1:0] r_data_out;

  logic w_sclk_s;
  logic w_ss_s;
  logic w_mosi_s;
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_drive;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // The ss chain clears to 0 so that a reset taken while ss is held low does
  // not produce a falling edge afterwards: the slave waits for a fresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b0;
      r_mosi_q    <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_ss_rise   <= 1'b0;
      r_ss_fall   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
      r_ss_d      <= w_ss_s;
      // mosi is delayed alongside the edge flags so a sample edge sees the
      // data bit that was on the wire when that edge arrived.
      r_mosi_q    <= w_mosi_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_sclk_fall <= ~w_sclk_s & r_sclk_d;
      r_ss_rise   <= w_ss_s & ~r_ss_d;
      r_ss_fall   <= ~w_ss_s & r_ss_d;
    end
  end

  assign w_lead   = r_cpol ? r_sclk_fall : r_sclk_rise;
  assign w_trail  = r_cpol ? r_sclk_rise : r_sclk_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_drive  = r_cpha ? w_lead  : w_trail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_ss_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (r_ss_rise) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_cnt      <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_reload   <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy    <= 1'b0;
          r_miso_oe <= 1'b0;
          r_miso    <= 1'b0;
          r_reload  <= 1'b0;
          if (r_ss_fall) begin
            r_busy    <= 1'b1;
            r_miso_oe <= 1'b1;
            r_cnt     <= '0;
            r_cpol    <= cpol;
            r_cpha    <= cpha;
            if (cpha) begin
              r_tx <= data_in;
            end else begin
              // No drive edge precedes the first sample in CPHA=0, so the MSB
              // has to be on the line as soon as we are selected.
              r_miso <= data_in[WIDTH-1];
              r_tx   <= {data_in[WIDTH-2:0], 1'b0};
            end
          end
        end
        S_ACTIVE: begin
          // ss release wins over any sclk edge seen in the same cycle.
          if (r_ss_rise) begin
            r_busy    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
            r_cnt     <= '0;
            r_reload  <= 1'b0;
          end else if (w_sample) begin
            r_rx <= (WIDTH-1)'({r_rx, r_mosi_q});
            if (r_cnt == C_LAST) begin
              r_data_out <= {r_rx, r_mosi_q};
              r_rx_valid <= 1'b1;
              r_cnt      <= '0;
              r_tx       <= data_in;
              r_reload   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else if (w_drive) begin
            // The first drive edge after a completed word re-reads data_in, so
            // the host may update it in response to rx_valid.
            if (r_reload) begin
              r_miso   <= data_in[WIDTH-1];
              r_tx     <= {data_in[WIDTH-2:0], 1'b0};
              r_reload <= 1'b0;
            end else begin
              r_miso <= r_tx[WIDTH-1];
              r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign busy     = r_busy;
  assign rx_valid = r_rx_valid;
  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_slave                                                    |
// | Purpose  : Self-checking bench for spi_slave with a behavioural SPI master |
// |            and a received-word scoreboard.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_spi_slave;

  localparam int HALF = 80;  // half sclk period in ns (8 clk periods)

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol;
  logic       cpha;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic [7:0] data_in;
  logic       miso;
  logic       miso_oe;
  logic       busy;
  logic       rx_valid;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] obs_q[$];
  int         rx_cnt = 0;

  logic mon_en = 1'b0;
  logic prev_miso = 1'b0;
  int   m3_glitch = 0;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpol     (cpol),
    .cpha     (cpha),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .data_in  (data_in),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .busy     (busy),
    .rx_valid (rx_valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Capture every received word; comparisons happen in the test tasks.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      obs_q.push_back(data_out);
      rx_cnt++;
    end
  end

  // Mode 3: miso must not move while sclk is high inside a transaction.
  always @(negedge clk) begin
    if (mon_en && ss === 1'b0 && sclk === 1'b1 && miso !== prev_miso) m3_glitch++;
    prev_miso = miso;
  end

  // Behavioural master: shifts nbits of mo out MSB-first, returns bits seen.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        #HALF;
        mi[i] = miso;
        sclk  = ~cpol;
        #HALF;
        sclk  = cpol;
      end else begin
        #HALF;
        sclk = ~cpol;
        mosi = mo[i];
        #HALF;
        mi[i] = miso;
        sclk  = cpol;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (miso_oe !== 1'b0)  begin bad++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
    total++; if (miso !== 1'b0)     begin bad++; $display("FAIL reset_miso: got %b expected 0", miso); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rxv: got %b expected 0", rx_valid); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h expected 00", data_out); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_modes();
    logic [7:0] mi, e, o;
    int base;
    for (int m = 0; m < 4; m++) begin
      cpol = ((m & 2) != 0);
      cpha = ((m & 1) != 0);
      sclk = cpol;
      data_in = 8'h3C;
      repeat (10) @(negedge clk);
      base = rx_cnt;
      m3_glitch = 0;
      exp_rx_q.push_back(8'hA5);
      exp_tx_q.push_back(8'h3C);
      mon_en = (m == 3);
      ss = 1'b0;
      #60;
      total++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin
        bad++; $display("FAIL mode%0d_busy_rise: got busy=%b oe=%b expected 1 1", m, busy, miso_oe);
      end
      spi_bits(8'hA5, 8, mi);
      e = exp_tx_q.pop_front();
      total++; if (mi !== e) begin bad++; $display("FAIL mode%0d_miso: got %h expected %h", m, mi, e); end
      #HALF;
      ss = 1'b1;
      mon_en = 1'b0;
      #15;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mode%0d_busy_hold: got %b expected 1", m, busy); end
      #30;
      total++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
        bad++; $display("FAIL mode%0d_release: got busy=%b oe=%b miso=%b expected 0 0 0", m, busy, miso_oe, miso);
      end
      #100;
      total++; if (rx_cnt - base != 1) begin bad++; $display("FAIL mode%0d_pulses: got %0d expected 1", m, rx_cnt - base); end
      while (exp_rx_q.size() > 0) begin
        e = exp_rx_q.pop_front();
        total++;
        if (obs_q.size() == 0) begin
          bad++; $display("FAIL mode%0d_rx: got none expected %h", m, e);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin bad++; $display("FAIL mode%0d_rx: got %h expected %h", m, o, e); end
        end
      end
      obs_q.delete();
      if (m == 3) begin
        total++; if (m3_glitch != 0) begin bad++; $display("FAIL mode3_miso_edge: got %0d changes while sclk high expected 0", m3_glitch); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2, e, o;
    int base;
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; data_in = 8'hF0;
    repeat (10) @(negedge clk);
    base = rx_cnt;
    exp_rx_q.push_back(8'h81); exp_rx_q.push_back(8'h7E);
    exp_tx_q.push_back(8'hF0); exp_tx_q.push_back(8'h0F);
    ss = 1'b0;
    #60;
    fork
      begin
        spi_bits(8'h81, 8, mi1);
        spi_bits(8'h7E, 8, mi2);
      end
      begin
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        total++; if (n >= 400) begin bad++; $display("FAIL b2b_first_valid: got timeout expected rx_valid"); end
        data_in = 8'h0F;
      end
    join
    e = exp_tx_q.pop_front();
    total++; if (mi1 !== e) begin bad++; $display("FAIL b2b_miso1: got %h expected %h", mi1, e); end
    e = exp_tx_q.pop_front();
    total++; if (mi2 !== e) begin bad++; $display("FAIL b2b_miso2: got %h expected %h", mi2, e); end
    #HALF;
    ss = 1'b1;
    #150;
    total++; if (rx_cnt - base != 2) begin bad++; $display("FAIL b2b_pulses: got %0d expected 2", rx_cnt - base); end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL b2b_rx: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b_rx: got %h expected %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_abort();
    logic [7:0] mi, e, o;
    int base;
    base = rx_cnt;
    ss = 1'b0;
    #60;
    spi_bits(8'hC3, 4, mi);
    #HALF;
    ss = 1'b1;
    #150;
    total++; if (rx_cnt != base) begin bad++; $display("FAIL abort_pulses: got %0d expected 0", rx_cnt - base); end
    total++; if (data_out !== 8'h7E) begin bad++; $display("FAIL abort_dout: got %h expected 7e", data_out); end
    total++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      bad++; $display("FAIL abort_release: got busy=%b oe=%b expected 0 0", busy, miso_oe);
    end
    base = rx_cnt;
    exp_rx_q.push_back(8'h5A);
    ss = 1'b0;
    #60;
    spi_bits(8'h5A, 8, mi);
    #HALF;
    ss = 1'b1;
    #150;
    total++; if (rx_cnt - base != 1) begin bad++; $display("FAIL abort_next_pulses: got %0d expected 1", rx_cnt - base); end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL abort_next_rx: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL abort_next_rx: got %h expected %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, e, o;
    int base;
    base = rx_cnt;
    ss = 1'b0;
    #60;
    spi_bits(8'hE7, 5, mi);
    #3;
    rst = 1'b1;
    #10;
    rst = 1'b0;
    total++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl: got busy=%b oe=%b miso=%b rxv=%b expected 0 0 0 0", busy, miso_oe, miso, rx_valid);
    end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_dout: got %h expected 00", data_out); end
    // Rest of the interrupted word while ss stays low: must be ignored.
    spi_bits(8'hE7, 3, mi);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_ignore_busy: got %b expected 0", busy); end
    #HALF;
    ss = 1'b1;
    #150;
    total++; if (rx_cnt != base) begin bad++; $display("FAIL rstmid_pulses: got %0d expected 0", rx_cnt - base); end
    base = rx_cnt;
    exp_rx_q.push_back(8'h99);
    ss = 1'b0;
    #60;
    spi_bits(8'h99, 8, mi);
    #HALF;
    ss = 1'b1;
    #150;
    total++; if (rx_cnt - base != 1) begin bad++; $display("FAIL rstmid_next_pulses: got %0d expected 1", rx_cnt - base); end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL rstmid_next_rx: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rstmid_next_rx: got %h expected %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (responder) for the 8-bit SPI master in the same design; the master and slave must be able to talk to each other.
- Runs entirely in the system `clk` domain. External `sclk`, `ss` and `mosi` are synchronized and edge-detected; the block does not use `sclk` as a clock.
- Supports all four CPOL/CPHA modes, MSB-first, full duplex.
- Received words go to `data_out` with a `rx_valid` strobe. Transmit words are taken from `data_in`.

Parameters:
- WIDTH, 8, word length in bits (minimum 2).
- SYNC_STAGES, 2, flip-flop stages on `sclk`, `ss` and `mosi` (minimum 2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- cpol  in  1  idle level of `sclk`.
- cpha  in  1  0 = sample on the leading edge, 1 = sample on the trailing edge.
- sclk  in  1  serial clock from the master (asynchronous).
- ss  in  1  slave select, active-low (asynchronous).
- mosi  in  1  serial data from the master (asynchronous).
- data_in  in  WIDTH  word to transmit; captured at the points listed under Behaviour.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the `miso` pad driver; 1 while selected.
- busy  out  1  high while a transaction is active.
- rx_valid  out  1  one-cycle strobe: `data_out` has just been updated.
- data_out  out  WIDTH  last complete received word.

Behaviour:
- Reset: while `rst`=1 at a `clk` edge, all of the following are cleared: `miso`, `miso_oe`, `busy`, `rx_valid`, `data_out`, the shift registers and the bit counter; the state becomes IDLE. Reset overrides everything, including mid-transaction; a partial word is discarded.
- Input synchronization and edge detection:
  - `sclk`, `ss` and `mosi` each pass through SYNC_STAGES flops.
  - An edge is detected by comparing the last sync stage with a one-flop delayed copy of it.
  - `ss_s` and `mosi_s` denote the synchronized `ss` and `mosi`.
- Edge definitions:
  - leading edge = rising if `cpol`=0, falling if `cpol`=1; trailing edge = the opposite.
  - sample edge = leading if `cpha`=0, trailing if `cpha`=1; drive edge = the other one.
- Mode latching: `cpol` and `cpha` are latched when the transaction starts; changes mid-transaction are ignored.
- Clock ratio: `sclk` high and low times must each be at least 4 `clk` periods. Behaviour is undefined below that.
- FSM, two states:
  - IDLE:
    - `busy`=0, `miso_oe`=0, `miso`=0.
    - On the falling edge of `ss_s`: go to ACTIVE, `busy`<=1, `miso_oe`<=1, bit counter <= 0.
      - If `cpha`=0: `miso` <= `data_in`[WIDTH-1] and tx shift <= `data_in` << 1.
      - If `cpha`=1: tx shift <= `data_in`.
  - ACTIVE:
    - Sample edge: rx shift <= {rx[WIDTH-2:0], `mosi_s`}; counter increments.
    - Drive edge: `miso` <= tx[WIDTH-1]; tx <= tx << 1.
      - With `cpha`=0 this covers bits 1..WIDTH-1.
      - With `cpha`=1 it covers bits 0..WIDTH-1.
    - Word complete (sample edge at counter = WIDTH-1):
      - `data_out` <= {rx[WIDTH-2:0], `mosi_s`}.
      - `rx_valid`=1 for exactly one cycle.
      - counter <= 0; tx shift <= `data_in`.
      - The next drive edge then outputs the MSB of the new word.
    - Back-to-back words are supported while `ss` stays low.
    - Rising edge of `ss_s`: return to IDLE; `busy`, `miso_oe` and `miso` go to 0 on the next cycle.
      - A partial word (counter != 0) is discarded with no `rx_valid`.
      - `data_out` keeps its last value.
- Latency: `rx_valid` rises SYNC_STAGES+2 `clk` cycles after the final sample edge appears at the `sclk` pin.
- Simultaneous events in one cycle:
  - `ss_s` rising together with an `sclk` edge: the `ss` rise takes priority and the `sclk` edge is ignored.
  - `sclk` edges in IDLE are ignored.
- `rx_valid` is 0 at all times other than the completion cycle.
- Width rules: the counter is ceil(log2(WIDTH)) bits and wraps only through the explicit reset to 0 at word completion.

Test Plan:
- Mode 0: master sends 0xA5 while `data_in`=0x3C.
  - `data_out`=0xA5 with exactly one `rx_valid` pulse.
  - `miso` bits sampled by the master are 0,0,1,1,1,1,0,0.
  - `busy`=1 from `ss` low until `ss` high, plus the sync delay.
- Modes 1, 2, 3: the same 0xA5 / 0x3C exchange with the matching master mode.
  - Identical results.
  - In mode 3 (`cpol`=1, `cpha`=1), `miso` changes only on falling `sclk` edges.
- Back-to-back: `ss` held low for 16 `sclk` cycles, master sends 0x81 then 0x7E; `data_in` is 0xF0, then changed to 0x0F after the first `rx_valid`.
  - Two `rx_valid` pulses with `data_out` 0x81, then 0x7E.
  - `miso` carries 0xF0, then 0x0F.
- Abort: `ss` is raised after 4 bits of 0xC3.
  - No `rx_valid`; `data_out` keeps its previous value.
  - `busy` and `miso_oe` return to 0.
  - The next full transfer of 0x5A is received correctly.
- Reset mid-transfer: `rst`=1 for 1 cycle after 5 bits.
  - All outputs are 0 on the next cycle.
  - The slave ignores the rest of that `ss`-low period until `ss` goes high and low again.
  - The following 0x99 transfer is received correctly.
